// File: rtl/bp_me_cce_mem_cmd_arbiter_pkg.sv
// Shared BedRock mem-command types, widths and the header-to-beat-count helper.
// The helper is also used by the CCE tracer on the merged port.
package bp_me_cce_mem_cmd_arbiter_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int dword_width_gp     = 64;
    localparam int cce_block_width_gp = 512;
    localparam int max_beats_gp       = cce_block_width_gp / dword_width_gp;
    localparam int lg_dword_width_gp  = $clog2(dword_width_gp);
    localparam int beat_cnt_width_gp  = 5;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    // Size is log2 of the message length in bytes.
    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [15:0]               payload;
        bp_bedrock_msg_size_e      size;
        logic [paddr_width_gp-1:0] addr;
        bp_bedrock_mem_type_e      msg_type;
    } cce_mem_hdr_t;

    localparam int cce_mem_hdr_width_gp = $bits(cce_mem_hdr_t);

    function automatic logic [beat_cnt_width_gp-1:0] bedrock_mem_beats(input cce_mem_hdr_t hdr);
        logic [10:0]                  bits;
        logic [beat_cnt_width_gp-1:0] n;
        bits = 11'd8 << hdr.size;
        n    = beat_cnt_width_gp'(bits >> lg_dword_width_gp);
        if (hdr.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr}) begin
            return (n == '0) ? beat_cnt_width_gp'(1) : n;
        end
        return '0;
    endfunction

endpackage

// File: rtl/bp_me_cce_mem_cmd_arbiter_rr_select.sv
// Round-robin requester select starting at rr_ptr_i, combinational.
// When hold_i is seen at a clock edge the current choice is frozen until hold_i drops.
module bp_me_rr_select #(
    parameter int num_req_p     = 2,
    parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [num_req_p-1:0]     req_i,
    input  logic [lg_num_req_lp-1:0] rr_ptr_i,
    input  logic                     hold_i,
    output logic [lg_num_req_lp-1:0] sel_o
);

    logic                     hold_q, hold_d;
    logic [lg_num_req_lp-1:0] held_sel_q, held_sel_d;
    logic [lg_num_req_lp-1:0] scan_sel;
    logic                     found;
    int                       idx;

    always_comb begin
        scan_sel = rr_ptr_i;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                scan_sel = idx[lg_num_req_lp-1:0];
            end
        end
    end

    always_comb begin
        sel_o      = hold_q ? held_sel_q : scan_sel;
        hold_d     = hold_i;
        held_sel_d = sel_o;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q     <= 1'b0;
            held_sel_q <= '0;
        end else begin
            hold_q     <= hold_d;
            held_sel_q <= held_sel_d;
        end
    end

endmodule

// File: rtl/bp_me_cce_mem_cmd_arbiter.sv
// Round-robin mux of num_req_p header+data mem-command streams onto one port; zero latency.
// Downstream ready passes straight to the granted requester; the grant is locked for a write burst.
module bp_me_cce_mem_cmd_arbiter
    import bp_me_cce_mem_cmd_arbiter_pkg::*;
#(
    parameter int num_req_p     = 2,
    localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int hdr_w_lp      = cce_mem_hdr_width_gp,
    localparam int dw_lp         = dword_width_gp
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [num_req_p*hdr_w_lp-1:0] req_header_i,
    input  logic [num_req_p-1:0]          req_header_v_i,
    output logic [num_req_p-1:0]          req_header_ready_and_o,
    input  logic [num_req_p*dw_lp-1:0]    req_data_i,
    input  logic [num_req_p-1:0]          req_data_v_i,
    output logic [num_req_p-1:0]          req_data_ready_and_o,
    output logic [hdr_w_lp-1:0]           mem_header_o,
    output logic                          mem_header_v_o,
    input  logic                          mem_header_ready_and_i,
    output logic [dw_lp-1:0]              mem_data_o,
    output logic                          mem_data_v_o,
    input  logic                          mem_data_ready_and_i,
    output logic [lg_num_req_lp-1:0]      grant_id_o,
    output logic                          busy_o
);

    typedef enum logic {e_idle, e_data} state_e;

    localparam logic [lg_num_req_lp-1:0] last_id_lp = lg_num_req_lp'(num_req_p - 1);

    state_e                         state_q, state_d;
    logic [lg_num_req_lp-1:0]       rr_ptr_q, rr_ptr_d;
    logic [lg_num_req_lp-1:0]       owner_q, owner_d;
    logic [beat_cnt_width_gp-1:0]   beat_cnt_q, beat_cnt_d;

    cce_mem_hdr_t                   hdr_arr  [num_req_p];
    logic [dw_lp-1:0]               data_arr [num_req_p];
    logic [lg_num_req_lp-1:0]       sel;
    logic [beat_cnt_width_gp-1:0]   beats;
    logic                           hold;
    logic                           hdr_hs;
    logic                           data_hs;

    function automatic logic [lg_num_req_lp-1:0] next_id(input logic [lg_num_req_lp-1:0] id);
        return (id == last_id_lp) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            hdr_arr[i]  = cce_mem_hdr_t'(req_header_i[i*hdr_w_lp +: hdr_w_lp]);
            data_arr[i] = req_data_i[i*dw_lp +: dw_lp];
        end
    end

    // Freeze the selection while a presented header waits for downstream ready.
    assign hold = (state_q == e_idle) && !reset_i && (|req_header_v_i) && !mem_header_ready_and_i;

    bp_me_rr_select #(
        .num_req_p     (num_req_p),
        .lg_num_req_lp (lg_num_req_lp)
    ) u_rr_select (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .req_i    (req_header_v_i),
        .rr_ptr_i (rr_ptr_q),
        .hold_i   (hold),
        .sel_o    (sel)
    );

    always_comb begin
        state_d                = state_q;
        rr_ptr_d               = rr_ptr_q;
        owner_d                = owner_q;
        beat_cnt_d             = beat_cnt_q;
        req_header_ready_and_o = '0;
        req_data_ready_and_o   = '0;
        mem_header_o           = hdr_arr[sel];
        mem_header_v_o         = 1'b0;
        mem_data_o             = data_arr[owner_q];
        mem_data_v_o           = 1'b0;
        grant_id_o             = '0;
        busy_o                 = 1'b0;
        hdr_hs                 = 1'b0;
        data_hs                = 1'b0;
        beats                  = bedrock_mem_beats(hdr_arr[sel]);

        // Reset gates every handshake output asynchronously; partial bursts are dropped.
        if (!reset_i) begin
            case (state_q)
                e_idle: begin
                    grant_id_o                  = sel;
                    mem_header_v_o              = |req_header_v_i;
                    req_header_ready_and_o[sel] = mem_header_ready_and_i;
                    hdr_hs                      = mem_header_v_o && mem_header_ready_and_i;
                    if (hdr_hs) begin
                        if (beats == '0) begin
                            rr_ptr_d = next_id(sel);
                        end else begin
                            state_d    = e_data;
                            owner_d    = sel;
                            beat_cnt_d = beats - 1'b1;
                        end
                    end
                end
                e_data: begin
                    grant_id_o                    = owner_q;
                    busy_o                        = 1'b1;
                    mem_data_v_o                  = req_data_v_i[owner_q];
                    req_data_ready_and_o[owner_q] = mem_data_ready_and_i;
                    data_hs                       = mem_data_v_o && mem_data_ready_and_i;
                    if (data_hs) begin
                        if (beat_cnt_q == '0) begin
                            state_d  = e_idle;
                            rr_ptr_d = next_id(owner_q);
                        end else begin
                            beat_cnt_d = beat_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = e_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_beats_fit_block: assert property (@(posedge clk_i) disable iff (reset_i)
        hdr_hs |-> (beats <= beat_cnt_width_gp'(max_beats_gp)));
    a_no_hdr_in_data: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == e_data) |-> !(|(req_header_v_i & req_header_ready_and_o)));
`endif

endmodule

// File: tb/tb_bp_me_cce_mem_cmd_arbiter.sv
// Directed bench for the mem-command arbiter, three requesters.
module tb_bp_me_cce_mem_cmd_arbiter;
    import bp_me_cce_mem_cmd_arbiter_pkg::*;

    localparam int n_lp  = 3;
    localparam int hw_lp = cce_mem_hdr_width_gp;
    localparam int dw_lp = dword_width_gp;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [n_lp*hw_lp-1:0]   req_header;
    logic [n_lp-1:0]         hv, hr;
    logic [n_lp*dw_lp-1:0]   req_data;
    logic [n_lp-1:0]         dv, dr;
    cce_mem_hdr_t            mem_header;
    logic                    mem_hv, mem_hr;
    logic [dw_lp-1:0]        mem_data;
    logic                    mem_dv, mem_dr;
    logic [1:0]              grant;
    logic                    busy;

    int n_vec = 0;
    int n_mis = 0;
    int k;
    int last_c;

    always #5 clk = ~clk;

    bp_me_cce_mem_cmd_arbiter #(.num_req_p(n_lp)) dut (
        .clk_i                  (clk),
        .reset_i                (reset),
        .req_header_i           (req_header),
        .req_header_v_i         (hv),
        .req_header_ready_and_o (hr),
        .req_data_i             (req_data),
        .req_data_v_i           (dv),
        .req_data_ready_and_o   (dr),
        .mem_header_o           (mem_header),
        .mem_header_v_o         (mem_hv),
        .mem_header_ready_and_i (mem_hr),
        .mem_data_o             (mem_data),
        .mem_data_v_o           (mem_dv),
        .mem_data_ready_and_i   (mem_dr),
        .grant_id_o             (grant),
        .busy_o                 (busy)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input int r, input bp_bedrock_mem_type_e t, input logic [2:0] sz,
                           input logic [39:0] a);
        cce_mem_hdr_t h;
        h          = '0;
        h.msg_type = t;
        h.size     = bp_bedrock_msg_size_e'(sz);
        h.addr     = a;
        h.payload  = 16'(r);
        req_header[r*hw_lp +: hw_lp] = h;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        req_header = '0;
        req_data   = '0;
        hv         = '0;
        dv         = '0;
        mem_hr     = 1'b0;
        mem_dr     = 1'b0;
        #1;
        reset  = 1'b1;
        hv     = 3'b011;
        mem_hr = 1'b1;
        #1;
        expect_eq("rst_hdr_v", mem_hv, 0);
        expect_eq("rst_hdr_rdy", hr, 0);
        expect_eq("rst_data_v", mem_dv, 0);
        expect_eq("rst_grant", grant, 0);
        expect_eq("rst_busy", busy, 0);
        step();
        reset = 1'b0;

        // Two requesters issuing reads every cycle alternate.
        set_hdr(0, e_bedrock_mem_rd, 3'd6, 40'h100);
        set_hdr(1, e_bedrock_mem_rd, 3'd6, 40'h200);
        hv = 3'b011;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_eq("alt_grant", grant, i % 2);
            expect_eq("alt_hdr_rdy", hr, (i % 2 == 0) ? 3'b001 : 3'b010);
            expect_eq("alt_addr", mem_header.addr, (i % 2 == 0) ? 40'h100 : 40'h200);
            expect_eq("alt_busy", busy, 0);
            step();
        end

        // uc_wr 64B burst from req0 while req1 waits with a read.
        set_hdr(0, e_bedrock_mem_uc_wr, 3'd6, 40'h300);
        set_hdr(1, e_bedrock_mem_rd, 3'd3, 40'h400);
        hv     = 3'b011;
        mem_dr = 1'b1;
        #1;
        expect_eq("burst_grant", grant, 0);
        expect_eq("burst_hdr_rdy", hr, 3'b001);
        step();
        hv = 3'b010;
        for (int b = 0; b < 8; b++) begin
            req_data[0 +: 64]  = 64'hD000 + 64'(b);
            req_data[64 +: 64] = 64'hBAD;
            dv = 3'b011;
            #1;
            expect_eq("burst_data", mem_data, 64'hD000 + 64'(b));
            expect_eq("burst_data_rdy", dr, 3'b001);
            expect_eq("burst_hdr_stall", hr, 3'b000);
            expect_eq("burst_hdr_v", mem_hv, 0);
            step();
        end
        dv = '0;
        #1;
        expect_eq("after_burst_grant", grant, 1);
        expect_eq("after_burst_hdr_rdy", hr, 3'b010);
        expect_eq("after_burst_busy", busy, 0);
        step();
        hv = '0;

        // 32B write from req1 with downstream data ready toggling.
        set_hdr(1, e_bedrock_mem_wr, 3'd5, 40'h500);
        hv = 3'b010;
        #1;
        expect_eq("tog_grant", grant, 1);
        step();
        hv     = '0;
        k      = 0;
        last_c = -1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            mem_dr              = (c % 2 == 0);
            req_data[64 +: 64]  = 64'hE000 + 64'(k);
            dv                  = 3'b010;
            #1;
            expect_eq("tog_data_v", mem_dv, 1);
            expect_eq("tog_data_rdy", dr, mem_dr ? 3'b010 : 3'b000);
            if (mem_dr) begin
                expect_eq("tog_data", mem_data, 64'hE000 + 64'(k));
                k++;
                last_c = c;
            end
            step();
        end
        expect_eq("tog_beats", k, 4);
        expect_eq("tog_last_cycle", last_c, 6);
        req_data[64 +: 64] = 64'hE004;
        mem_dr = 1'b1;
        #1;
        expect_eq("tog_no_extra_rdy", dr, 0);
        expect_eq("tog_no_extra_v", mem_dv, 0);
        expect_eq("tog_busy_done", busy, 0);
        dv = '0;
        step();

        // Reset after beat 3 of an 8-beat burst.
        set_hdr(0, e_bedrock_mem_uc_wr, 3'd6, 40'h600);
        hv = 3'b001;
        #1;
        expect_eq("rb_grant", grant, 0);
        step();
        hv = '0;
        for (int b = 0; b < 3; b++) begin
            req_data[0 +: 64] = 64'hF000 + 64'(b);
            dv = 3'b001;
            #1;
            expect_eq("rb_data", mem_data, 64'hF000 + 64'(b));
            step();
        end
        set_hdr(1, e_bedrock_mem_rd, 3'd3, 40'h700);
        hv    = 3'b010;
        reset = 1'b1;
        #1;
        expect_eq("rb_async_data_v", mem_dv, 0);
        expect_eq("rb_async_data_rdy", dr, 0);
        expect_eq("rb_async_hdr_v", mem_hv, 0);
        expect_eq("rb_async_hdr_rdy", hr, 0);
        expect_eq("rb_async_busy", busy, 0);
        step();
        step();
        reset = 1'b0;
        dv    = '0;
        set_hdr(2, e_bedrock_mem_rd, 3'd3, 40'h800);
        hv     = 3'b110;
        mem_hr = 1'b0;
        #1;
        expect_eq("rb_ptr_cleared", grant, 1);
        expect_eq("rb_idle", busy, 0);
        expect_eq("rb_hdr_v", mem_hv, 1);

        // Only req2 valid: granted at once, pointer wraps to 0.
        hv     = 3'b100;
        mem_hr = 1'b1;
        #1;
        expect_eq("solo_grant", grant, 2);
        expect_eq("solo_hdr_rdy", hr, 3'b100);
        step();
        set_hdr(0, e_bedrock_mem_rd, 3'd3, 40'h900);
        hv = 3'b111;
        #1;
        expect_eq("wrap_grant", grant, 0);
        expect_eq("wrap_hdr_rdy", hr, 3'b001);
        step();

        // Header stalled 5 cycles while another requester raises valid.
        set_hdr(0, e_bedrock_mem_rd, 3'd3, 40'hA00);
        hv     = 3'b001;
        mem_hr = 1'b0;
        #1;
        expect_eq("hold_grant0", grant, 0);
        step();
        hv = 3'b011;
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_eq("hold_grant", grant, 0);
            expect_eq("hold_addr", mem_header.addr, 40'hA00);
            expect_eq("hold_hdr_rdy", hr, 0);
            step();
        end
        mem_hr = 1'b1;
        #1;
        expect_eq("hold_release_grant", grant, 0);
        expect_eq("hold_release_rdy", hr, 3'b001);
        step();
        hv = 3'b010;
        #1;
        expect_eq("hold_next_grant", grant, 1);
        step();
        hv = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
